// File: rtl/circle_points.sv
// circle_points: midpoint-circle point generator.
// Streams the 8 octant-mirrored candidates of every midpoint step over a
// valid/ready port, then pulses done. All outputs are registered.
// Optional feature macro: CIRCLE_CLIP_EN. When defined, candidates outside
// 0..255 are dropped. When undefined, every candidate is emitted and
// coordinates wrap modulo 256.
module circle_points (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [7:0] r,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] px,
    output logic [7:0] py,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_STEP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cx_q, cx_d, cy_q, cy_d;
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic signed [10:0] d_q, d_d;
    logic [2:0]        k_q, k_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        px_q, px_d, py_q, py_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              adv;
    logic              step_dec, step_cont;
    logic [8:0]        y_inc, x_dec;
    logic signed [10:0] ys, xs, d_step;
    logic signed [9:0] ccx, ccy, cdx, cdy, cand_x, cand_y;
    logic              clip_c;

    // Midpoint step arithmetic; x may drop to -1 only for r=0, so compare signed.
    always_comb begin
        step_dec  = ~d_q[10];
        y_inc     = {1'b0, y_q} + 9'd1;
        x_dec     = step_dec ? ({1'b0, x_q} - 9'd1) : {1'b0, x_q};
        ys        = $signed({2'b00, y_inc});
        xs        = $signed({{2{x_dec[8]}}, x_dec});
        if (step_dec) begin
            d_step = d_q + ((ys - xs) <<< 1) + 11'sd1;
        end else begin
            d_step = d_q + (ys <<< 1) + 11'sd1;
        end
        step_cont = (xs >= ys);
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        k_d     = k_q;
`ifdef CIRCLE_CLIP_EN
        adv     = out_ready || !out_valid_q;
`else
        adv     = out_valid_q && out_ready;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d    = cx;
                    cy_d    = cy;
                    x_d     = r;
                    y_d     = 8'd0;
                    d_d     = 11'sd1 - $signed({3'b000, r});
                    k_d     = 3'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (adv) begin
                    k_d = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                y_d     = y_inc[7:0];
                x_d     = x_dec[7:0];
                d_d     = d_step;
                k_d     = 3'd0;
                state_d = step_cont ? S_EMIT : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Candidate point for the upcoming cycle, formed from next-state values.
    always_comb begin
        ccx    = $signed({2'b00, cx_d});
        ccy    = $signed({2'b00, cy_d});
        cdx    = $signed({2'b00, x_d});
        cdy    = $signed({2'b00, y_d});
        cand_x = ccx + cdx;
        cand_y = ccy + cdy;
        case (k_d)
            3'd1: begin cand_x = ccx + cdy; cand_y = ccy + cdx; end
            3'd2: begin cand_x = ccx - cdy; cand_y = ccy + cdx; end
            3'd3: begin cand_x = ccx - cdx; cand_y = ccy + cdy; end
            3'd4: begin cand_x = ccx - cdx; cand_y = ccy - cdy; end
            3'd5: begin cand_x = ccx - cdy; cand_y = ccy - cdx; end
            3'd6: begin cand_x = ccx + cdy; cand_y = ccy - cdx; end
            3'd7: begin cand_x = ccx + cdx; cand_y = ccy - cdy; end
            default: begin cand_x = ccx + cdx; cand_y = ccy + cdy; end
        endcase
`ifdef CIRCLE_CLIP_EN
        clip_c = (cand_x < 10'sd0) || (cand_x > 10'sd255) ||
                 (cand_y < 10'sd0) || (cand_y > 10'sd255);
`else
        clip_c = 1'b0;
`endif
        out_valid_d = (state_d == S_EMIT) && !clip_c;
        px_d        = out_valid_d ? cand_x[7:0] : px_q;
        py_d        = out_valid_d ? cand_y[7:0] : py_q;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cx_q        <= 8'd0;
            cy_q        <= 8'd0;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            d_q         <= 11'sd0;
            k_q         <= 3'd0;
            out_valid_q <= 1'b0;
            px_q        <= 8'd0;
            py_q        <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            d_q         <= d_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            px_q        <= px_d;
            py_q        <= py_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign px        = px_q;
    assign py        = py_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_circle_points.sv
// Directed bench for circle_points: hand-computed point lists, cycle timing,
// backpressure hold, ignored start, mid-run reset and the clipping boundary.
module tb_circle_points;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic [7:0] cx, cy, r;
    logic       out_valid, busy, done;
    logic [7:0] px, py;

    circle_points dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cx        (cx),
        .cy        (cy),
        .r         (r),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .px        (px),
        .py        (py),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int gx [64];
    int gy [64];
    int npts, done_cyc, first_cyc, n_done;

    int e2x [16] = '{102, 100, 100,  98,  98, 100, 100, 102,
                     102, 101,  99,  98,  98,  99, 101, 102};
    int e2y [16] = '{100, 102, 102, 100, 100,  98,  98, 100,
                     101, 102, 102, 101,  99,  98,  98,  99};
`ifdef CIRCLE_CLIP_EN
    int ncl = 4;
    int ecx [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    int ecy [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
`else
    int ncl = 8;
    int ecx [8] = '{1, 0, 0, 255, 255, 0, 0, 1};
    int ecy [8] = '{0, 1, 1, 0, 0, 255, 255, 0};
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: ready=1; 1: ready 1,0,0 pattern; 2: extra start mid-run; 3: reset after 5th point.
    task automatic run(input int ax, input int ay, input int ar, input int mode);
        int  prev_stall, hx, hy, stop_cyc;
        bit  fin;
        logic rdy;
        npts = 0; done_cyc = -1; first_cyc = -1; n_done = 0;
        prev_stall = 0; hx = 0; hy = 0; stop_cyc = 1000; fin = 0;
        cx = 8'(ax); cy = 8'(ay); r = 8'(ar);
        start = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            if (mode == 3 && npts >= 5) begin
                rst = 1'b1; out_ready = 1'b0;
                @(posedge clk); @(negedge clk);
                check("rst_valid", out_valid, 0);
                check("rst_px", px, 0);
                check("rst_py", py, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                rst = 1'b0;
                fin = 1;
            end else begin
                rdy = (mode == 1) ? ((cyc % 3) == 1) : 1'b1;
                out_ready = rdy;
                if (mode == 2 && cyc == 4) begin
                    start = 1'b1; cx = 8'd50; r = 8'd7;
                end else begin
                    start = 1'b0;
                end
                if (prev_stall != 0) begin
                    check("hold_px", px, hx);
                    check("hold_py", py, hy);
                    check("hold_valid", out_valid, 1);
                end
                if (out_valid && first_cyc < 0) first_cyc = cyc;
                if (out_valid && rdy && npts < 64) begin
                    gx[npts] = px; gy[npts] = py; npts++;
                end
                prev_stall = (out_valid && !rdy) ? 1 : 0;
                hx = px; hy = py;
                if (done) begin
                    n_done++;
                    if (done_cyc < 0) begin
                        done_cyc = cyc;
                        stop_cyc = cyc + ((mode == 2) ? 25 : 1);
                    end
                end
                if (cyc == done_cyc + 1) begin
                    check("busy_after_done", busy, 0);
                    check("valid_after_done", out_valid, 0);
                end
                if (cyc >= stop_cyc) fin = 1;
                else begin
                    @(posedge clk); @(negedge clk);
                end
            end
        end
        start = 1'b0;
        if (!fin) check("timeout", 0, 1);
    endtask

    task automatic check_r2(input string tag);
        check({tag, "_npts"}, npts, 16);
        check({tag, "_ndone"}, n_done, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_x%0d", tag, i), gx[i], e2x[i]);
            check($sformatf("%s_y%0d", tag, i), gy[i], e2y[i]);
        end
    endtask

    task automatic check_r0(input string tag);
        check({tag, "_npts"}, npts, 8);
        check({tag, "_first"}, first_cyc, 1);
        check({tag, "_done_cyc"}, done_cyc, 10);
        check({tag, "_ndone"}, n_done, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_x%0d", tag, i), gx[i], 10);
            check($sformatf("%s_y%0d", tag, i), gy[i], 10);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        cx = 8'd0; cy = 8'd0; r = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_px", px, 0);
        check("reset_py", py, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        // rst and start together: reset wins.
        start = 1'b1; cx = 8'd5; r = 8'd3;
        @(posedge clk); @(negedge clk);
        check("rststart_busy", busy, 0);
        check("rststart_valid", out_valid, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("idle_busy", busy, 0);

        run(10, 10, 0, 0);
        check_r0("r0");

        // Back-to-back: started in the cycle right after done.
        run(100, 100, 2, 0);
        check_r2("r2");
        check("r2_first", first_cyc, 1);
        check("r2_done_cyc", done_cyc, 19);

        run(100, 100, 2, 1);
        check_r2("bp");

        run(100, 100, 2, 2);
        check_r2("busy_start");

        run(0, 0, 1, 0);
        check("clip_npts", npts, ncl);
        check("clip_ndone", n_done, 1);
        for (int i = 0; i < ncl; i++) begin
            check($sformatf("clip_x%0d", i), gx[i], ecx[i]);
            check($sformatf("clip_y%0d", i), gy[i], ecy[i]);
        end

        run(100, 100, 2, 3);
        check("midrst_npts", npts, 5);
        run(10, 10, 0, 0);
        check_r0("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
